// File: rtl/apb_ucpd_rx_buf_if.sv
// apb_ucpd_rx_buf_if: byte-stream and RXDR read bundle for the UCPD receive buffer.
//
// Signals (direction as seen from the buffer, i.e. the slave modport):
//   msg_start, wr_en, wr_data, msg_end, msg_abort  in   decoder side (SOP, byte, EOP, error)
//   rd_en, ovr_clr                                 in   register side (RXDR pop, overflow clear)
//   rd_data, rxne, level, ovr                      out  FWFT head, status and sticky overflow
//   msg_done, rx_err, rx_paysize                   out  per-message completion pulses and size
// The master modport is the mirror image, used by whoever drives the buffer.
interface apb_ucpd_rx_buf_if #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned PSW   = 10
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          msg_start;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          msg_end;
   logic          msg_abort;
   logic          rd_en;
   logic          ovr_clr;
   logic [DW-1:0] rd_data;
   logic          rxne;
   logic [LW-1:0] level;
   logic          ovr;
   logic          msg_done;
   logic          rx_err;
   logic [PSW-1:0] rx_paysize;

   modport master (
      output msg_start, wr_en, wr_data, msg_end, msg_abort, rd_en, ovr_clr,
      input  rd_data, rxne, level, ovr, msg_done, rx_err, rx_paysize
   );

   modport slave (
      input  msg_start, wr_en, wr_data, msg_end, msg_abort, rd_en, ovr_clr,
      output rd_data, rxne, level, ovr, msg_done, rx_err, rx_paysize
   );
endinterface

// File: rtl/apb_ucpd_rx_buf.sv
// apb_ucpd_rx_buf: UCPD receive byte buffer. Decoded bytes pass through a CRC_BYTES-deep
// holdback so the trailing CRC never reaches the DEPTH-entry FWFT FIFO read through RXDR.
// Payload bytes per message are counted (saturating) and reported on close.
//
// Ports:
//   ic_clk  in  kernel clock, everything sampled on its rising edge
//   ic_rst  in  synchronous active-high reset
//   bus     apb_ucpd_rx_buf_if.slave: decoder strobes in, RXDR data and status out
//
// Optional feature: define UCPD_RXBUF_COMMIT_EN for store-and-forward. Readable data is then
// bounded by a commit pointer that only advances on a good EOP; an abort, short message or
// restart rewinds the write pointer to where the message began. Without it the buffer is
// cut-through and pushed bytes are readable at once.
module apb_ucpd_rx_buf #(
   parameter int unsigned DW        = 8,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned CRC_BYTES = 4,
   parameter int unsigned PSW       = 10
) (
   input logic              ic_clk,
   input logic              ic_rst,
   apb_ucpd_rx_buf_if.slave bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned HW = $clog2(CRC_BYTES + 1);

   typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

   state_e         state;
   logic [DW-1:0]  mem [DEPTH];
   logic [DW-1:0]  hb [CRC_BYTES];   // hb[0] newest, hb[CRC_BYTES-1] oldest
   logic [HW-1:0]  hb_cnt;
   logic [LW-1:0]  wr_ptr;
   logic [LW-1:0]  rd_ptr;
   logic [PSW-1:0] pay_cnt;
   logic [PSW-1:0] paysize;
   logic           ovr;
   logic           msg_done;
   logic           rx_err;
`ifdef UCPD_RXBUF_COMMIT_EN
   logic [LW-1:0]  start_ptr;
   logic [LW-1:0]  commit_ptr;
`endif

   logic [LW-1:0]  used;
   logic [LW-1:0]  readable;
   logic           rxne;
   logic           full;
   logic           pop;
   logic           busy;
   logic           byte_in;
   logic           push_req;
   logic           push;
   logic           ovf;

   // Full always counts every written entry, committed or not.
   assign used = wr_ptr - rd_ptr;
   assign full = (used == LW'(DEPTH));
`ifdef UCPD_RXBUF_COMMIT_EN
   assign readable = commit_ptr - rd_ptr;
`else
   assign readable = used;
`endif
   assign rxne = (readable != '0);
   assign pop  = bus.rd_en & rxne;
   assign busy = (state != StIdle);

   // Control strobes outrank data: a byte arriving with abort/end/start is dropped.
   assign byte_in  = busy & bus.wr_en & ~bus.msg_abort & ~bus.msg_end & ~bus.msg_start;
   assign push_req = byte_in & (state == StStream);
   // A pop in the same cycle frees the slot the push needs.
   assign push     = push_req & (~full | pop);
   assign ovf      = push_req & full & ~pop;

   assign bus.rd_data    = rxne ? mem[rd_ptr[AW-1:0]] : '0;
   assign bus.rxne       = rxne;
   assign bus.level      = readable;
   assign bus.ovr        = ovr;
   assign bus.msg_done   = msg_done;
   assign bus.rx_err     = rx_err;
   assign bus.rx_paysize = paysize;

   // Data path needs no reset: stale contents are never visible.
   always_ff @(posedge ic_clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= hb[CRC_BYTES-1];
      end
      if (byte_in) begin
         hb[0] <= bus.wr_data;
         for (int unsigned i = 1; i < CRC_BYTES; i++) begin
            hb[i] <= hb[i-1];
         end
      end
   end

   always_ff @(posedge ic_clk) begin
      if (ic_rst) begin
         state    <= StIdle;
         hb_cnt   <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pay_cnt  <= '0;
         paysize  <= '0;
         ovr      <= 1'b0;
         msg_done <= 1'b0;
         rx_err   <= 1'b0;
`ifdef UCPD_RXBUF_COMMIT_EN
         start_ptr  <= '0;
         commit_ptr <= '0;
`endif
      end else begin
         msg_done <= 1'b0;
         rx_err   <= 1'b0;
         ovr      <= (ovr & ~bus.ovr_clr) | ovf;

         if (pop) begin
            rd_ptr <= rd_ptr + LW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + LW'(1);
         end
         // Payload counts every byte past the holdback, even one lost to overflow.
         if (push_req && (pay_cnt != '1)) begin
            pay_cnt <= pay_cnt + PSW'(1);
         end

         case (state)
            StIdle: begin
               if (bus.msg_start) begin
                  state   <= StFill;
                  hb_cnt  <= '0;
                  pay_cnt <= '0;
`ifdef UCPD_RXBUF_COMMIT_EN
                  start_ptr <= wr_ptr;
`endif
               end
            end
            StFill, StStream: begin
               if (bus.msg_abort) begin
                  rx_err <= 1'b1;
                  state  <= StIdle;
`ifdef UCPD_RXBUF_COMMIT_EN
                  wr_ptr <= start_ptr;
`endif
               end else if (bus.msg_end) begin
                  state <= StIdle;
                  if (state == StFill) begin
                     // Shorter than the CRC: nothing of it is payload.
                     paysize <= '0;
                     rx_err  <= 1'b1;
`ifdef UCPD_RXBUF_COMMIT_EN
                     wr_ptr <= start_ptr;
`endif
                  end else begin
                     paysize  <= pay_cnt;
                     msg_done <= 1'b1;
`ifdef UCPD_RXBUF_COMMIT_EN
                     commit_ptr <= wr_ptr;
`endif
                  end
               end else if (bus.msg_start) begin
                  // Restart: abort the current message and open a new one at once.
                  // start_ptr is unchanged since the rewound wr_ptr equals it.
                  rx_err  <= 1'b1;
                  state   <= StFill;
                  hb_cnt  <= '0;
                  pay_cnt <= '0;
`ifdef UCPD_RXBUF_COMMIT_EN
                  wr_ptr <= start_ptr;
`endif
               end else if (byte_in && (state == StFill)) begin
                  hb_cnt <= hb_cnt + HW'(1);
                  if (hb_cnt == HW'(CRC_BYTES - 1)) begin
                     state <= StStream;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_ucpd_rx_buf.sv
// Self-checking bench for apb_ucpd_rx_buf: directed scenarios plus a randomized run,
// all compared against a queue-based message model.
module tb_apb_ucpd_rx_buf;
   localparam int unsigned DW        = 8;
   localparam int unsigned DEPTH     = 16;
   localparam int unsigned CRC_BYTES = 4;
   localparam int unsigned PSW       = 10;
   localparam int unsigned LW        = $clog2(DEPTH) + 1;
   localparam int          PAY_MAX   = (1 << PSW) - 1;
`ifdef UCPD_RXBUF_COMMIT_EN
   localparam bit COMMIT = 1'b1;
`else
   localparam bit COMMIT = 1'b0;
`endif

   logic ic_clk = 1'b0;
   logic ic_rst = 1'b1;

   apb_ucpd_rx_buf_if #(.DW(DW), .DEPTH(DEPTH), .PSW(PSW)) bus ();

   apb_ucpd_rx_buf #(
      .DW(DW), .DEPTH(DEPTH), .CRC_BYTES(CRC_BYTES), .PSW(PSW)
   ) dut (
      .ic_clk(ic_clk),
      .ic_rst(ic_rst),
      .bus(bus)
   );

   always #5 ic_clk = ~ic_clk;

   int checks = 0;
   int errors = 0;

   // Model: m_store holds stored bytes oldest first; in store-and-forward the first
   // m_commit of them are readable and the rest belong to the open message.
   logic [DW-1:0] m_store[$];
   logic [DW-1:0] m_hold[$];
   int m_commit, m_cnt, m_paysize;
   bit m_rx, m_ovr, m_done, m_err;

   function automatic int m_level();
      return COMMIT ? m_commit : m_store.size();
   endfunction

   function automatic logic [DW-1:0] m_head();
      return (m_level() > 0) ? m_store[0] : '0;
   endfunction

   function automatic void m_discard();
      m_hold.delete();
      if (COMMIT) begin
         while (m_store.size() > m_commit) void'(m_store.pop_back());
      end
   endfunction

   function automatic void m_reset();
      m_store.delete();
      m_hold.delete();
      m_commit = 0; m_cnt = 0; m_paysize = 0;
      m_rx = 0; m_ovr = 0; m_done = 0; m_err = 0;
   endfunction

   task automatic clear_inputs();
      bus.msg_start = 0; bus.wr_en = 0; bus.wr_data = '0; bus.msg_end = 0;
      bus.msg_abort = 0; bus.rd_en = 0; bus.ovr_clr = 0;
   endtask

   task automatic reset_dut();
      clear_inputs();
      ic_rst = 1'b1;
      @(posedge ic_clk); #1;
      ic_rst = 1'b0;
      m_reset();
   endtask

   // Drive one cycle of stimulus, advance the model, and land 1 time unit past the edge.
   task automatic step(input bit st, input bit wr, input logic [DW-1:0] d,
                       input bit en, input bit ab, input bit rd, input bit clr);
      bit ovf;
      logic [DW-1:0] oldest;
      bus.msg_start = st; bus.wr_en = wr; bus.wr_data = d; bus.msg_end = en;
      bus.msg_abort = ab; bus.rd_en = rd; bus.ovr_clr = clr;
      ovf = 0;
      if (rd && m_level() > 0) begin
         void'(m_store.pop_front());
         if (COMMIT) m_commit--;
      end
      m_done = 0; m_err = 0;
      if (m_rx) begin
         if (ab) begin
            m_err = 1; m_discard(); m_rx = 0;
         end else if (en) begin
            if (m_cnt < CRC_BYTES) begin
               m_err = 1; m_paysize = 0; m_discard();
            end else begin
               m_done = 1;
               m_paysize = (m_cnt - CRC_BYTES > PAY_MAX) ? PAY_MAX : m_cnt - CRC_BYTES;
               m_hold.delete();
               m_commit = m_store.size();
            end
            m_rx = 0;
         end else if (st) begin
            m_err = 1; m_discard(); m_cnt = 0;
         end else if (wr) begin
            m_cnt++;
            m_hold.push_back(d);
            if (m_hold.size() > CRC_BYTES) begin
               oldest = m_hold.pop_front();
               if (m_store.size() < DEPTH) m_store.push_back(oldest);
               else ovf = 1;
            end
         end
      end else if (st) begin
         m_rx = 1; m_cnt = 0; m_hold.delete();
      end
      m_ovr = (m_ovr && !clr) || ovf;
      @(posedge ic_clk); #1;
      clear_inputs();
   endtask

   task automatic test_reset();
      reset_dut();
      checks++; if (bus.rd_data !== '0) begin errors++;
         $display("FAIL reset_rd_data got %0h want 0", bus.rd_data); end
      checks++; if (bus.rxne !== 1'b0) begin errors++;
         $display("FAIL reset_rxne got %0b want 0", bus.rxne); end
      checks++; if (bus.level !== '0) begin errors++;
         $display("FAIL reset_level got %0d want 0", bus.level); end
      checks++; if (bus.ovr !== 1'b0) begin errors++;
         $display("FAIL reset_ovr got %0b want 0", bus.ovr); end
      checks++; if (bus.msg_done !== 1'b0 || bus.rx_err !== 1'b0) begin errors++;
         $display("FAIL reset_pulses got done=%0b err=%0b want 0 0", bus.msg_done, bus.rx_err); end
      checks++; if (bus.rx_paysize !== '0) begin errors++;
         $display("FAIL reset_paysize got %0d want 0", bus.rx_paysize); end
   endtask

   task automatic test_good_msg();
      logic [DW-1:0] exp;
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 10; i++) step(0, 1, DW'(i), 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      checks++; if (bus.msg_done !== 1'b1 || bus.rx_err !== 1'b0) begin errors++;
         $display("FAIL good_pulse got done=%0b err=%0b want 1 0", bus.msg_done, bus.rx_err); end
      checks++; if (bus.rx_paysize !== PSW'(6)) begin errors++;
         $display("FAIL good_paysize got %0d want 6", bus.rx_paysize); end
      checks++; if (bus.level !== LW'(6) || bus.rxne !== 1'b1) begin errors++;
         $display("FAIL good_level got %0d/%0b want 6/1", bus.level, bus.rxne); end
      checks++; if (bus.rd_data !== 8'h01) begin errors++;
         $display("FAIL good_head got %0h want 01", bus.rd_data); end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (bus.msg_done !== 1'b0) begin errors++;
         $display("FAIL good_done_width got %0b want 0", bus.msg_done); end
      for (int i = 0; i < DEPTH + 2 && m_level() > 0; i++) begin
         exp = m_head();
         checks++; if (bus.rd_data !== exp) begin errors++;
            $display("FAIL good_drain got %0h want %0h", bus.rd_data, exp); end
         step(0, 0, 0, 0, 0, 1, 0);
      end
      checks++; if (bus.rxne !== 1'b0 || bus.rd_data !== '0) begin errors++;
         $display("FAIL good_empty got rxne=%0b data=%0h want 0 0", bus.rxne, bus.rd_data); end
   endtask

   task automatic test_short();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, DW'(8'hA0 + i), 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      checks++; if (bus.rx_err !== 1'b1 || bus.msg_done !== 1'b0) begin errors++;
         $display("FAIL short_pulse got err=%0b done=%0b want 1 0", bus.rx_err, bus.msg_done); end
      checks++; if (bus.rx_paysize !== '0) begin errors++;
         $display("FAIL short_paysize got %0d want 0", bus.rx_paysize); end
      checks++; if (bus.level !== LW'(m_level())) begin errors++;
         $display("FAIL short_level got %0d want %0d", bus.level, m_level()); end
   endtask

   task automatic test_overflow();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 24; i++) step(0, 1, DW'(8'h20 + i), 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      checks++; if (bus.level !== LW'(16) || bus.ovr !== 1'b1) begin errors++;
         $display("FAIL ovf_full got level=%0d ovr=%0b want 16 1", bus.level, bus.ovr); end
      checks++; if (bus.rx_paysize !== PSW'(20)) begin errors++;
         $display("FAIL ovf_paysize got %0d want 20", bus.rx_paysize); end
      // Push into a full FIFO while popping.
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, DW'(8'h50 + i), 0, 0, 0, 0);
      step(0, 1, 8'h54, 0, 0, 1, 0);
      checks++; if (bus.level !== LW'(m_level()) || bus.rd_data !== m_head()) begin errors++;
         $display("FAIL ovf_pushpop got level=%0d data=%0h want %0d %0h",
                  bus.level, bus.rd_data, m_level(), m_head()); end
      // Overflow coinciding with ovr_clr keeps the flag.
      step(0, 1, 8'h55, 0, 0, 0, 1);
      checks++; if (bus.ovr !== 1'b1) begin errors++;
         $display("FAIL ovf_clr_race got %0b want 1", bus.ovr); end
      step(0, 0, 0, 0, 0, 0, 1);
      checks++; if (bus.ovr !== 1'b0) begin errors++;
         $display("FAIL ovf_clear got %0b want 0", bus.ovr); end
      step(0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_abort();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, DW'(8'h70 + i), 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0, 0);
      checks++; if (bus.rx_err !== 1'b1 || bus.msg_done !== 1'b0) begin errors++;
         $display("FAIL abort_pulse got err=%0b done=%0b want 1 0", bus.rx_err, bus.msg_done); end
      checks++; if (bus.level !== LW'(COMMIT ? 0 : 4)) begin errors++;
         $display("FAIL abort_level got %0d want %0d", bus.level, COMMIT ? 0 : 4); end
      checks++; if (bus.rx_paysize !== PSW'(m_paysize)) begin errors++;
         $display("FAIL abort_paysize got %0d want %0d", bus.rx_paysize, m_paysize); end
   endtask

   task automatic test_restart();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, DW'(8'h90 + i), 0, 0, 0, 0);
      step(1, 1, 8'hFF, 0, 0, 0, 0);
      checks++; if (bus.rx_err !== 1'b1 || bus.msg_done !== 1'b0) begin errors++;
         $display("FAIL restart_err got err=%0b done=%0b want 1 0", bus.rx_err, bus.msg_done); end
      for (int i = 0; i < 6; i++) step(0, 1, DW'(8'hB0 + i), 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0);
      checks++; if (bus.msg_done !== 1'b1 || bus.rx_paysize !== PSW'(2)) begin errors++;
         $display("FAIL restart_msg got done=%0b paysize=%0d want 1 2", bus.msg_done, bus.rx_paysize); end
      checks++; if (bus.level !== LW'(m_level()) || bus.rd_data !== m_head()) begin errors++;
         $display("FAIL restart_level got %0d/%0h want %0d/%0h",
                  bus.level, bus.rd_data, m_level(), m_head()); end
   endtask

   task automatic test_end_with_byte();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 1, DW'(8'hC0 + i), 0, 0, 0, 0);
      step(0, 1, 8'hEE, 1, 0, 0, 0);
      checks++; if (bus.rx_paysize !== PSW'(2) || bus.msg_done !== 1'b1) begin errors++;
         $display("FAIL endwr_paysize got %0d/%0b want 2/1", bus.rx_paysize, bus.msg_done); end
      checks++; if (bus.level !== LW'(m_level())) begin errors++;
         $display("FAIL endwr_level got %0d want %0d", bus.level, m_level()); end
   endtask

   task automatic test_reset_mid();
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 1, DW'(8'hD0 + i), 0, 0, 0, 0);
      reset_dut();
      checks++; if (bus.level !== '0 || bus.rxne !== 1'b0 || bus.rd_data !== '0) begin errors++;
         $display("FAIL rstmid_fifo got level=%0d rxne=%0b data=%0h want 0 0 0",
                  bus.level, bus.rxne, bus.rd_data); end
      checks++; if (bus.msg_done !== 1'b0 || bus.rx_err !== 1'b0 || bus.rx_paysize !== '0)
         begin errors++;
         $display("FAIL rstmid_status got done=%0b err=%0b pay=%0d want 0 0 0",
                  bus.msg_done, bus.rx_err, bus.rx_paysize); end
      // FSM must be idle: a late EOP is ignored.
      step(0, 0, 0, 1, 0, 0, 0);
      checks++; if (bus.msg_done !== 1'b0 || bus.rx_err !== 1'b0) begin errors++;
         $display("FAIL rstmid_idle got done=%0b err=%0b want 0 0", bus.msg_done, bus.rx_err); end
   endtask

   task automatic test_random();
      bit st, wr, en, ab, rd, clr;
      for (int n = 0; n < 3000; n++) begin
         st  = ($urandom_range(0, 99) < 3);
         wr  = ($urandom_range(0, 99) < 60);
         en  = ($urandom_range(0, 99) < 4);
         ab  = ($urandom_range(0, 199) < 2);
         rd  = ($urandom_range(0, 99) < 30);
         clr = ($urandom_range(0, 99) < 3);
         step(st, wr, DW'($urandom), en, ab, rd, clr);
         checks++;
         if (bus.level !== LW'(m_level()) || bus.rxne !== (m_level() > 0) ||
             bus.rd_data !== m_head()) begin
            errors++;
            $display("FAIL rand_fifo cyc %0d got level=%0d rxne=%0b data=%0h want %0d %0b %0h",
                     n, bus.level, bus.rxne, bus.rd_data, m_level(), m_level() > 0, m_head());
         end
         checks++;
         if (bus.ovr !== m_ovr || bus.msg_done !== m_done || bus.rx_err !== m_err ||
             bus.rx_paysize !== PSW'(m_paysize)) begin
            errors++;
            $display("FAIL rand_status cyc %0d got ovr=%0b done=%0b err=%0b pay=%0d want %0b %0b %0b %0d",
                     n, bus.ovr, bus.msg_done, bus.rx_err, bus.rx_paysize,
                     m_ovr, m_done, m_err, m_paysize);
         end
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_good_msg();
      test_short();
      test_overflow();
      reset_dut();
      test_abort();
      test_restart();
      test_end_with_byte();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
